obstacle_manager: RTL and testbench
===================================

OBSTACLE_MANAGER -- requirements
Module: obstacle_manager

Interface
REQ-001 Parameter NUM_OBST, default 4: number of obstacle slots (1..8).
REQ-002 Parameter SPAWN_GAP, default 300: processed frames between spawn attempts.
REQ-003 Parameter SPEED, default 2: pixels moved left per processed frame.
REQ-004 Parameter OBST_SIZE, default 8: obstacle half-extent, in pixels.
REQ-005 Parameters SPAWN_X = 639, SPAWN_Y = 400, LANE_OFS = 40, LIVES_INIT = 3, INVULN_FRAMES = 60 set spawn position, alternate lane offset, starting lives and invulnerability length.
REQ-006 Clk  input  1: sole clock, all state updates on rising edge.
REQ-007 Reset  input  1: synchronous, active-high reset.
REQ-008 frame_tick  input  1: one-cycle frame strobe, synchronous to Clk.
REQ-009 pause / restart  input  1 each: freeze gameplay / leave game-over.
REQ-010 PlayerX, PlayerY, PlayerS  input  10 each: player centre and half-size.
REQ-011 obst_x, obst_y  output  NUM_OBST*10: flattened slot centres, slot i at bits [10i+9:10i].
REQ-012 obst_active  output  NUM_OBST: per-slot valid.
REQ-013 lives  output  3; hit  output  1; game_over  output  1; busy  output  1.

Function
REQ-014 FSM states: IDLE, MOVE, SPAWN, SCAN, DONE, GAMEOVER.
REQ-015 IDLE -> MOVE on frame_tick=1 with pause=0; frame_tick with pause=1 is discarded, with no state change.
REQ-016 frame_tick in any state other than IDLE is ignored, and busy=1 in MOVE, SPAWN, SCAN and DONE.
REQ-017 MOVE, 1 cycle: each active slot with x < SPEED is deactivated; otherwise x <= x - SPEED. All slots update in parallel.
REQ-018 MOVE also decrements the invulnerability counter when it is nonzero.
REQ-019 MOVE also advances the spawn counter modulo SPAWN_GAP.
REQ-020 SPAWN, 1 cycle: if the spawn counter equals SPAWN_GAP-1 and a free slot exists, the lowest-index free slot is loaded with (SPAWN_X, spawn Y) and set active.
REQ-021 If no slot is free at a spawn attempt, the spawn is skipped silently and the counter still wraps.
REQ-022 SCAN, NUM_OBST cycles: slot k is tested in cycle k.
REQ-023 Overlap test: |PlayerX-ox| < PlayerS+OBST_SIZE AND |PlayerY-oy| < PlayerS+OBST_SIZE, using 11-bit unsigned absolute differences with no wrap.
REQ-024 The first overlapping active slot in a scan is deactivated, and only when the invulnerability counter is 0.
REQ-025 That same hit decrements lives (saturating at 0) and loads the invulnerability counter with INVULN_FRAMES.
REQ-026 Later overlaps in the same scan have no effect: at most one life is lost per frame.
REQ-027 DONE, 1 cycle: hit=1 for exactly this cycle if a hit was registered in the scan; next state is GAMEOVER if lives==0, else IDLE.
REQ-028 Latency: a tick accepted in cycle t gives updated positions at t+2, spawn visible at t+3, and hit high at cycle t+3+NUM_OBST.
REQ-029 GAMEOVER: game_over=1, all outputs hold, frame_tick and pause are ignored.
REQ-030 restart=1 in GAMEOVER performs the reset actions of REQ-032 and returns to IDLE; restart is ignored in all other states.

Reset
REQ-031 Reset overrides every other input in any state, including mid-SCAN.
REQ-032 Reset values: state IDLE, all obst_active=0, obst_x/obst_y=0, lives=LIVES_INIT, spawn and invulnerability counters 0, hit=0, game_over=0, busy=0, LFSR=16'hACE1.

Configuration
REQ-033 With OBST_MGR_LFSR_EN defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11) advances once per accepted tick; spawn Y = SPAWN_Y - LANE_OFS when bit 0 is 1, else SPAWN_Y.
REQ-034 Without OBST_MGR_LFSR_EN: no LFSR is instantiated and spawn Y is always SPAWN_Y.

Structure
REQ-035 The shared package game_pkg holds coord_t (10-bit), the manager state enum, and screen constants (640x480).
REQ-036 The overlap test lives in sub-module obst_aabb_check, which is combinational and instantiated once, multiplexed across slots during SCAN.

Verification
REQ-037 Scenario, spawn: SPAWN_GAP=4, pause=0, 4 ticks -> slot0 active at (639,400) after the 4th tick; after the 8th tick, slot1 active and slot0 x=631.
REQ-038 Scenario, full: NUM_OBST=2, SPAWN_GAP=1, 3 ticks -> only slots 0 and 1 active, no error, third spawn dropped.
REQ-039 Scenario, despawn: slot at x=1 with SPEED=2, one tick -> slot inactive, x unchanged.
REQ-040 Scenario, single hit: player at (635,400), PlayerS=8, two slots overlapping -> lives 3->2, one hit pulse, only slot0 cleared.
REQ-041 Scenario, invulnerability and pause: a second overlap within 60 frames -> lives unchanged; ticks with pause=1 -> no movement and counters frozen.
REQ-042 Scenario, game over and reset: lives reach 0 -> game_over=1 and outputs frozen; restart -> lives=3, no slots active; Reset asserted mid-SCAN -> all REQ-032 values on the next cycle.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game types: coordinate type, obstacle-manager state encoding and screen geometry.
package game_pkg;

  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;

  typedef logic [9:0] coord_t;

  typedef enum logic [2:0] {
    StIdle,
    StMove,
    StSpawn,
    StScan,
    StDone,
    StGameOver
  } mgr_state_e;

endpackage

// File: rtl/obst_aabb_check.sv
// Combinational axis-aligned box overlap test between the player and one obstacle.
module obst_aabb_check
  import game_pkg::*;
#(
  parameter int unsigned OBST_SIZE = 8
) (
  input  coord_t     player_x_i,
  input  coord_t     player_y_i,
  input  logic [9:0] player_s_i,
  input  coord_t     obst_x_i,
  input  coord_t     obst_y_i,
  output logic       overlap_o
);

  logic [10:0] px, py, ox, oy, dx, dy, reach;

  // 11-bit arithmetic so neither the distance nor the reach can wrap
  always_comb begin
    px        = {1'b0, player_x_i};
    py        = {1'b0, player_y_i};
    ox        = {1'b0, obst_x_i};
    oy        = {1'b0, obst_y_i};
    dx        = (px >= ox) ? (px - ox) : (ox - px);
    dy        = (py >= oy) ? (py - oy) : (oy - py);
    reach     = {1'b0, player_s_i} + 11'(OBST_SIZE);
    overlap_o = (dx < reach) && (dy < reach);
  end

endmodule

// File: rtl/obstacle_manager.sv
// Obstacle slot manager: per-frame move, spawn, collision scan and lives/game-over tracking.
// Optional OBST_MGR_LFSR_EN adds a 16-bit LFSR that picks the spawn lane.
module obstacle_manager
  import game_pkg::*;
#(
  parameter int unsigned NUM_OBST      = 4,
  parameter int unsigned SPAWN_GAP     = 300,
  parameter int unsigned SPEED         = 2,
  parameter int unsigned OBST_SIZE     = 8,
  parameter int unsigned SPAWN_X       = SCREEN_W - 1,
  parameter int unsigned SPAWN_Y       = 400,
  parameter int unsigned LANE_OFS      = 40,
  parameter int unsigned LIVES_INIT    = 3,
  parameter int unsigned INVULN_FRAMES = 60
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  frame_tick,
  input  logic                  pause,
  input  logic                  restart,
  input  logic [9:0]            PlayerX,
  input  logic [9:0]            PlayerY,
  input  logic [9:0]            PlayerS,
  output logic [NUM_OBST*10-1:0] obst_x,
  output logic [NUM_OBST*10-1:0] obst_y,
  output logic [NUM_OBST-1:0]   obst_active,
  output logic [2:0]            lives,
  output logic                  hit,
  output logic                  game_over,
  output logic                  busy
);

  localparam int unsigned CntW = $clog2(SPAWN_GAP + 1);
  localparam int unsigned InvW = $clog2(INVULN_FRAMES + 2);
  localparam int unsigned IdxW = (NUM_OBST > 1) ? $clog2(NUM_OBST) : 1;

  mgr_state_e          state_q, state_d;
  coord_t              ox_q [NUM_OBST];
  coord_t              ox_d [NUM_OBST];
  coord_t              oy_q [NUM_OBST];
  coord_t              oy_d [NUM_OBST];
  logic [NUM_OBST-1:0] act_q, act_d;
  logic [2:0]          lives_q, lives_d;
  logic [CntW-1:0]     spawn_cnt_q, spawn_cnt_d;
  logic [InvW-1:0]     invuln_q, invuln_d;
  logic                hit_seen_q, hit_seen_d;
  logic [IdxW-1:0]     scan_idx_q, scan_idx_d;

  logic            clear, accept, lane_sel, overlap, free_found;
  logic [IdxW-1:0] free_idx;
  coord_t          spawn_y;

  assign clear  = Reset || ((state_q == StGameOver) && restart);
  assign accept = (state_q == StIdle) && frame_tick && !pause;

`ifdef OBST_MGR_LFSR_EN
  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (accept) lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  always_ff @(posedge Clk) begin
    if (clear) lfsr_q <= 16'hACE1;
    else       lfsr_q <= lfsr_d;
  end

  assign lane_sel = lfsr_q[0];
`else
  assign lane_sel = 1'b0;
`endif

  assign spawn_y = lane_sel ? coord_t'(SPAWN_Y - LANE_OFS) : coord_t'(SPAWN_Y);

  obst_aabb_check #(
    .OBST_SIZE(OBST_SIZE)
  ) u_aabb (
    .player_x_i(PlayerX),
    .player_y_i(PlayerY),
    .player_s_i(PlayerS),
    .obst_x_i  (ox_q[scan_idx_q]),
    .obst_y_i  (oy_q[scan_idx_q]),
    .overlap_o (overlap)
  );

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NUM_OBST - 1; i >= 0; i--) begin
      if (!act_q[i]) begin
        free_found = 1'b1;
        free_idx   = IdxW'(i);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ox_d        = ox_q;
    oy_d        = oy_q;
    act_d       = act_q;
    lives_d     = lives_q;
    spawn_cnt_d = spawn_cnt_q;
    invuln_d    = invuln_q;
    hit_seen_d  = hit_seen_q;
    scan_idx_d  = scan_idx_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d    = StMove;
          hit_seen_d = 1'b0;
        end
      end
      StMove: begin
        for (int i = 0; i < NUM_OBST; i++) begin
          if (act_q[i]) begin
            if (ox_q[i] < coord_t'(SPEED)) act_d[i] = 1'b0;
            else                           ox_d[i]  = ox_q[i] - coord_t'(SPEED);
          end
        end
        if (invuln_q != '0) invuln_d = invuln_q - InvW'(1);
        spawn_cnt_d = (spawn_cnt_q == CntW'(SPAWN_GAP - 1)) ? '0 : spawn_cnt_q + CntW'(1);
        state_d     = StSpawn;
      end
      StSpawn: begin
        // Counter just wrapped to 0 in MOVE, i.e. it stood at SPAWN_GAP-1 for this frame
        if ((spawn_cnt_q == '0) && free_found) begin
          ox_d[free_idx]  = coord_t'(SPAWN_X);
          oy_d[free_idx]  = spawn_y;
          act_d[free_idx] = 1'b1;
        end
        scan_idx_d = '0;
        state_d    = StScan;
      end
      StScan: begin
        if (overlap && act_q[scan_idx_q] && (invuln_q == '0) && !hit_seen_q) begin
          act_d[scan_idx_q] = 1'b0;
          lives_d           = (lives_q != 3'd0) ? lives_q - 3'd1 : 3'd0;
          invuln_d          = InvW'(INVULN_FRAMES);
          hit_seen_d        = 1'b1;
        end
        if (scan_idx_q == IdxW'(NUM_OBST - 1)) state_d = StDone;
        else                                   scan_idx_d = scan_idx_q + IdxW'(1);
      end
      StDone:     state_d = (lives_q == 3'd0) ? StGameOver : StIdle;
      StGameOver: state_d = StGameOver;
      default:    state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (clear) begin
      state_q     <= StIdle;
      ox_q        <= '{default: '0};
      oy_q        <= '{default: '0};
      act_q       <= '0;
      lives_q     <= 3'(LIVES_INIT);
      spawn_cnt_q <= '0;
      invuln_q    <= '0;
      hit_seen_q  <= 1'b0;
      scan_idx_q  <= '0;
    end else begin
      state_q     <= state_d;
      ox_q        <= ox_d;
      oy_q        <= oy_d;
      act_q       <= act_d;
      lives_q     <= lives_d;
      spawn_cnt_q <= spawn_cnt_d;
      invuln_q    <= invuln_d;
      hit_seen_q  <= hit_seen_d;
      scan_idx_q  <= scan_idx_d;
    end
  end

  always_comb begin
    obst_x = '0;
    obst_y = '0;
    for (int i = 0; i < NUM_OBST; i++) begin
      obst_x[10*i +: 10] = ox_q[i];
      obst_y[10*i +: 10] = oy_q[i];
    end
  end

  assign obst_active = act_q;
  assign lives       = lives_q;
  assign hit         = (state_q == StDone) && hit_seen_q;
  assign game_over   = (state_q == StGameOver);
  assign busy        = (state_q == StMove) || (state_q == StSpawn) ||
                       (state_q == StScan) || (state_q == StDone);

endmodule

// File: tb/tb_obstacle_manager.sv
// Directed bench: DUT A (4 slots, gap 4) covers spawn/pause/despawn/reset, DUT B (2 slots, gap 1)
// covers full table, hits, invulnerability, game over and restart.
module tb_obstacle_manager;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, ft_a, pause_a, restart_a;
  logic [9:0]  px_a, py_a, ps_a;
  logic [39:0] ox_a, oy_a;
  logic [3:0]  act_a;
  logic [2:0]  lives_a;
  logic        hit_a, go_a, busy_a;

  logic        rst_b, ft_b, pause_b, restart_b;
  logic [9:0]  px_b, py_b, ps_b;
  logic [19:0] ox_b, oy_b;
  logic [1:0]  act_b;
  logic [2:0]  lives_b;
  logic        hit_b, go_b, busy_b;

  int checks = 0;
  int errors = 0;
  int hits, cyc, hit_pos, tot;

  obstacle_manager #(
    .NUM_OBST (4),
    .SPAWN_GAP(4)
  ) u_dut_a (
    .Clk(clk), .Reset(rst_a), .frame_tick(ft_a), .pause(pause_a), .restart(restart_a),
    .PlayerX(px_a), .PlayerY(py_a), .PlayerS(ps_a),
    .obst_x(ox_a), .obst_y(oy_a), .obst_active(act_a),
    .lives(lives_a), .hit(hit_a), .game_over(go_a), .busy(busy_a)
  );

  obstacle_manager #(
    .NUM_OBST (2),
    .SPAWN_GAP(1)
  ) u_dut_b (
    .Clk(clk), .Reset(rst_b), .frame_tick(ft_b), .pause(pause_b), .restart(restart_b),
    .PlayerX(px_b), .PlayerY(py_b), .PlayerS(ps_b),
    .obst_x(ox_b), .obst_y(oy_b), .obst_active(act_b),
    .lives(lives_b), .hit(hit_b), .game_over(go_b), .busy(busy_b)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Strobe accepted at posedge t; returns at the negedge of cycle t+1
  task automatic go_tick(input logic sel_b);
    @(negedge clk);
    if (sel_b) ft_b = 1'b1; else ft_a = 1'b1;
    @(negedge clk);
    ft_a = 1'b0;
    ft_b = 1'b0;
  endtask

  // Counts busy cycles and hit pulses until the frame finishes, bounded
  task automatic settle(input logic sel_b);
    int n;
    hits = 0; cyc = 0; hit_pos = -1; n = 0;
    while ((sel_b ? busy_b : busy_a) && n < 40) begin
      cyc++;
      if (sel_b ? hit_b : hit_a) begin
        hits++;
        hit_pos = n;
      end
      @(negedge clk);
      n++;
    end
    check(sel_b ? "settle_b" : "settle_a", {63'd0, sel_b ? busy_b : busy_a}, 64'd0);
  endtask

  task automatic tick(input logic sel_b);
    go_tick(sel_b);
    settle(sel_b);
  endtask

  initial begin
    rst_a = 1'b1; ft_a = 1'b0; pause_a = 1'b0; restart_a = 1'b0;
    px_a = 10'd0; py_a = 10'd0; ps_a = 10'd1;
    rst_b = 1'b1; ft_b = 1'b0; pause_b = 1'b0; restart_b = 1'b0;
    px_b = 10'd0; py_b = 10'd0; ps_b = 10'd1;
    repeat (3) @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);

    check("rst_lives", 64'(lives_a), 64'd3);
    check("rst_active", 64'(act_a), 64'd0);
    check("rst_x", 64'(ox_a), 64'd0);
    check("rst_flags", {61'd0, busy_a, hit_a, go_a}, 64'd0);

    // Spawn cadence with gap 4
    tick(1'b0);
    check("frame_len", 64'(cyc), 64'd7);
    tick(1'b0); tick(1'b0);
    check("no_spawn_t3", 64'(act_a), 64'd0);
    tick(1'b0);
    check("spawn_t4_act", 64'(act_a), 64'b0001);
    check("spawn_t4_x", 64'(ox_a[9:0]), 64'd639);
    check("spawn_t4_y", 64'(oy_a[9:0]), 64'd400);

    // Paused tick is discarded: no frame, no move, no counter advance
    pause_a = 1'b1;
    tick(1'b0);
    pause_a = 1'b0;
    check("pause_busy", 64'(cyc), 64'd0);
    check("pause_x", 64'(ox_a[9:0]), 64'd639);

    repeat (4) tick(1'b0);
    check("t8_act", 64'(act_a), 64'b0011);
    check("t8_x0", 64'(ox_a[9:0]), 64'd631);
    check("t8_x1", 64'(ox_a[19:10]), 64'd639);

    @(negedge clk); restart_a = 1'b1;
    @(negedge clk); restart_a = 1'b0;
    check("restart_ignored", 64'(act_a), 64'b0011);

    repeat (12) tick(1'b0);
    check("t20_full", 64'(act_a), 64'b1111);
    check("t20_x0", 64'(ox_a[9:0]), 64'd607);

    repeat (303) tick(1'b0);
    check("t323_x0", 64'(ox_a[9:0]), 64'd1);

    // Despawn at t+2, lowest free slot refilled at t+3
    go_tick(1'b0);
    @(negedge clk);
    check("despawn_act", 64'(act_a[0]), 64'd0);
    check("despawn_x", 64'(ox_a[9:0]), 64'd1);
    @(negedge clk);
    check("respawn_act", 64'(act_a), 64'b1111);
    check("respawn_x", 64'(ox_a[9:0]), 64'd639);
    settle(1'b0);

    // Reset in the middle of the scan
    go_tick(1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    check("midscan_act", 64'(act_a), 64'd0);
    check("midscan_lives", 64'(lives_a), 64'd3);
    check("midscan_xy", {24'd0, ox_a[19:0], oy_a[19:0]}, 64'd0);
    check("midscan_flags", {61'd0, busy_a, hit_a, go_a}, 64'd0);

    // DUT B: table fills, third spawn dropped
    repeat (3) tick(1'b1);
    check("full_act", 64'(act_b), 64'b11);
    check("full_x", 64'(ox_b), 64'({10'd637, 10'd635}));
    check("full_y", 64'(oy_b), 64'({10'd400, 10'd400}));

    px_b = 10'd635; py_b = 10'd400; ps_b = 10'd8;
    tick(1'b1);
    check("hit_lives", 64'(lives_b), 64'd2);
    check("hit_act", 64'(act_b), 64'b10);
    check("hit_pulses", 64'(hits), 64'd1);
    check("hit_latency", 64'(hit_pos), 64'd4);
    check("hit_x1", 64'(ox_b[19:10]), 64'd635);

    tick(1'b1);
    check("invuln_lives", 64'(lives_b), 64'd2);
    check("invuln_pulses", 64'(hits), 64'd0);
    check("invuln_x", 64'(ox_b), 64'({10'd633, 10'd639}));

    px_b = 10'd320; py_b = 10'd240; ps_b = 10'd1023;
    tot = 0;
    for (int i = 0; i < 58; i++) begin tick(1'b1); tot += hits; end
    check("window1_hits", 64'(tot), 64'd0);
    check("window1_lives", 64'(lives_b), 64'd2);
    tick(1'b1);
    check("hit2_lives", 64'(lives_b), 64'd1);
    check("hit2_pulses", 64'(hits), 64'd1);
    tot = 0;
    for (int i = 0; i < 59; i++) begin tick(1'b1); tot += hits; end
    check("window2_hits", 64'(tot), 64'd0);
    tick(1'b1);
    check("hit3_lives", 64'(lives_b), 64'd0);
    check("hit3_pulses", 64'(hits), 64'd1);
    check("game_over", 64'(go_b), 64'd1);

    tick(1'b1);
    check("go_frozen_busy", 64'(cyc), 64'd0);
    check("go_frozen_flag", {62'd0, go_b, busy_b}, 64'b10);
    check("go_frozen_lives", 64'(lives_b), 64'd0);

    @(negedge clk); restart_b = 1'b1;
    @(negedge clk); restart_b = 1'b0;
    check("restart_lives", 64'(lives_b), 64'd3);
    check("restart_act", 64'(act_b), 64'd0);
    check("restart_go", 64'(go_b), 64'd0);
    check("restart_x", 64'(ox_b), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
